// File: rtl/sum_n_accumulator_if.sv
// rtl/sum_n_accumulator_if.sv - start/result handshake bundle for the Sum-of-N summation stage
interface sum_n_accumulator_if #(
    parameter int WIDTH = 4,
    parameter int SUM_W = 8
);
    logic             start;
    logic [WIDTH-1:0] n_in;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] cnt;
    logic             ovf;

    modport master (
        output start, n_in,
        input  busy, done, sum, cnt, ovf
    );

    modport slave (
        input  start, n_in,
        output busy, done, sum, cnt, ovf
    );
endinterface

// File: rtl/sum_n_accumulator.sv
// rtl/sum_n_accumulator.sv - down-counts N and accumulates N + (N-1) + ... + 1 with start/busy/done
module sum_n_accumulator #(
    parameter int WIDTH = 4,
    parameter int SUM_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    sum_n_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    // One extra bit on the adder exposes the carry-out used for the sticky overflow flag.
    logic [SUM_W:0]   add_full;
    assign add_full = {1'b0, acc_q} + {{(SUM_W + 1 - WIDTH){1'b0}}, cnt_q};

    // Internal state and datapath registers; reset discards any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update: load on accepted start, add-and-decrement while accumulating.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.n_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.n_in != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                acc_d = add_full[SUM_W-1:0];
                cnt_d = cnt_q - WIDTH'(1);
                if (add_full[SUM_W]) begin
                    ovf_d = 1'b1;
                end
                if (cnt_q == WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: every visible signal is a flop copy of the internal state, one cycle behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cnt  <= '0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.busy <= (state_q == ACC);
            bus.done <= (state_q == DONE);
            bus.sum  <= acc_q;
            bus.cnt  <= cnt_q;
            bus.ovf  <= ovf_q;
        end
    end

endmodule

// File: tb/tb_sum_n_accumulator.sv
// tb/tb_sum_n_accumulator.sv - directed and random checks of sum_n_accumulator against an arithmetic model
module tb_sum_n_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sum_n_accumulator_if #(.WIDTH(4), .SUM_W(8)) if8 ();
    sum_n_accumulator_if #(.WIDTH(4), .SUM_W(6)) if6 ();

    sum_n_accumulator #(.WIDTH(4), .SUM_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    sum_n_accumulator #(.WIDTH(4), .SUM_W(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if6.slave)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    bit   sel   = 1'b0;
    int   sw    = 8;

    logic       o_busy, o_done, o_ovf;
    logic [7:0] o_sum;
    logic [3:0] o_cnt;

    // Observed outputs of whichever instance is under test.
    always_comb begin
        o_busy = sel ? if6.busy : if8.busy;
        o_done = sel ? if6.done : if8.done;
        o_ovf  = sel ? if6.ovf  : if8.ovf;
        o_cnt  = sel ? if6.cnt  : if8.cnt;
        o_sum  = sel ? {2'b00, if6.sum} : if8.sum;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic [3:0] n);
        if (sel) begin
            if6.start = s;
            if6.n_in  = n;
            if8.start = 1'b0;
            if8.n_in  = 4'd0;
        end else begin
            if8.start = s;
            if8.n_in  = n;
            if6.start = 1'b0;
            if6.n_in  = 4'd0;
        end
    endtask

    // Sum of the first k terms of N, N-1, N-2, ...
    function automatic int partial(input int n, input int k);
        return k * n - (k * (k - 1)) / 2;
    endfunction

    // Launch a run of N from a negedge; check every cycle until done, then one idle cycle.
    // keep: start stays high across the run so the next call's first edge is the first IDLE edge.
    // inject: a second start with n_in=3 is pulsed while accumulating and must be ignored.
    task automatic run(input int n, input int next_n, input bit keep, input bit inject, input string tag);
        int modv;
        int p;
        int fin;
        modv = 1 << sw;
        fin  = partial(n, n);
        drive(1'b1, n[3:0]);
        @(posedge clk);
        @(negedge clk);
        if (keep) drive(1'b1, next_n[3:0]);
        else      drive(1'b0, 4'($urandom));
        for (int k = 1; k <= n + 1; k++) begin
            if (inject && k == 2) drive(1'b1, 4'd3);
            if (inject && k == 3) drive(1'b0, 4'd0);
            @(posedge clk);
            @(negedge clk);
            p = partial(n, k - 1);
            chk({tag, ".busy"}, 32'(o_busy), 32'(k <= n));
            chk({tag, ".done"}, 32'(o_done), 32'(k == n + 1));
            chk({tag, ".cnt"},  32'(o_cnt),  32'(n - (k - 1)));
            chk({tag, ".sum"},  32'(o_sum),  32'(p % modv));
            chk({tag, ".ovf"},  32'(o_ovf),  32'(p >= modv));
        end
        if (!keep) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".after_done"}, 32'(o_done), 32'd0);
            chk({tag, ".after_busy"}, 32'(o_busy), 32'd0);
            chk({tag, ".hold_sum"},   32'(o_sum),  32'(fin % modv));
        end
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        sel   = 1'b0;
        sw    = 8;
        drive(1'b0, 4'd0);
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(o_busy), 32'd0);
        chk("reset.done", 32'(o_done), 32'd0);
        chk("reset.sum",  32'(o_sum),  32'd0);
        chk("reset.cnt",  32'(o_cnt),  32'd0);
        chk("reset.ovf",  32'(o_ovf),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.done", 32'(o_done), 32'd0);

        run(5,  0, 1'b0, 1'b0, "n5");
        run(15, 0, 1'b0, 1'b0, "n15");
        run(1,  0, 1'b0, 1'b0, "n1");
        run(0,  0, 1'b0, 1'b0, "n0");
        run(6,  0, 1'b0, 1'b1, "ignore_start");
        run(7,  9, 1'b1, 1'b0, "hold_a");
        run(9,  0, 1'b0, 1'b0, "hold_b");

        // Asynchronous reset partway through a run of 10.
        drive(1'b1, 4'd10);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 4'd0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(o_busy), 32'd0);
        chk("abort.done", 32'(o_done), 32'd0);
        chk("abort.sum",  32'(o_sum),  32'd0);
        chk("abort.cnt",  32'(o_cnt),  32'd0);
        chk("abort.ovf",  32'(o_ovf),  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(o_done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.released_done", 32'(o_done), 32'd0);
        run(4, 0, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 15);
            run(r, 0, 1'b0, 1'b0, "rand8");
        end

        sel = 1'b1;
        sw  = 6;
        drive(1'b0, 4'd0);
        @(negedge clk);
        run(15, 0, 1'b0, 1'b0, "w6_n15");
        run(3,  0, 1'b0, 1'b0, "w6_n3");
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 15);
            run(r, 0, 1'b0, 1'b0, "rand6");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
